pre_spike_cnt_ctrl: RTL

Sequencer that owns the pre-synaptic spike-count SRAM and drives the combinational pre-neuron count update stage. It accepts per-neuron input events over a req/ack handshake and performs one read-modify-write per event through the update stage. On a time-reference request it sweeps the SRAM and clears every count. It sits between the input event arbiter (upstream) and the pre-neuron update logic plus count SRAM (downstream).

---
 rtl/pre_spike_cnt_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pre_spike_cnt_ctrl.sv
// pre_spike_cnt_ctrl
// Sequencer that owns the pre-synaptic spike-count SRAM. Each input event is
// one read-modify-write through the external combinational update stage; a
// time-reference request sweeps the SRAM and clears every count.
module pre_spike_cnt_ctrl #(
  parameter int N_PRE  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  // Event handshake from the input arbiter
  input  logic              event_req,
  input  logic [ADDR_W-1:0] event_addr,
  input  logic              event_spike,
  output logic              event_ack,
  // Time-reference clear handshake
  input  logic              ref_req,
  output logic              ref_done,
  output logic              busy,
  // Count SRAM
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  // Combinational pre-neuron update stage
  output logic [7:0]        upd_cnt,
  output logic              upd_event,
  output logic              upd_pulse,
  output logic              upd_ref,
  input  logic [7:0]        upd_cnt_next
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_SWEEP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PRE - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_spike;
  logic [ADDR_W-1:0] r_sweep;
  logic              w_addr_ok;

  // Compare at 32 bits so N_PRE == 2**ADDR_W does not wrap the bound to 0.
  assign w_addr_ok = (32'(r_addr) < 32'(N_PRE));

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; event_req has priority over ref_req in IDLE
  // NOTE: the default assignment first guarantees every path assigns the
  // output, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (event_req)    w_state_nxt = S_READ;
        else if (ref_req) w_state_nxt = S_SWEEP;
      end
      S_READ:  w_state_nxt = w_addr_ok ? S_WRITE : S_IDLE;
      S_WRITE: w_state_nxt = S_IDLE;
      S_SWEEP: if (r_sweep == LAST_ADDR) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Event capture and sweep address counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_addr  <= '0;
      r_spike <= 1'b0;
      r_sweep <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (event_req) begin
          r_addr  <= event_addr;
          r_spike <= event_spike;
        end else if (ref_req) begin
          r_sweep <= '0;
        end
      end else if (r_state == S_SWEEP) begin
        r_sweep <= r_sweep + 1'b1;
      end
    end
  end

  // Output decode from the registered state; idle outputs are all zero
  always_comb begin
    event_ack  = 1'b0;
    ref_done   = 1'b0;
    busy       = (r_state != S_IDLE);
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    upd_cnt    = '0;
    upd_event  = 1'b0;
    upd_pulse  = 1'b0;
    unique case (r_state)
      S_READ: begin
        if (w_addr_ok) begin
          sram_cs   = 1'b1;
          sram_addr = r_addr;
        end else begin
          // Out-of-range address: drop the event without touching the SRAM.
          event_ack = 1'b1;
        end
      end
      S_WRITE: begin
        upd_cnt    = sram_rdata;
        upd_event  = 1'b1;
        // Suppressing the pulse at 255 saturates the count instead of wrapping.
        upd_pulse  = r_spike & (sram_rdata != 8'hFF);
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = r_addr;
        sram_wdata = upd_cnt_next;
        event_ack  = 1'b1;
      end
      S_SWEEP: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = r_sweep;
      end
      S_DONE:  ref_done = 1'b1;
      default: ;
    endcase
  end

  assign upd_ref = 1'b0;

endmodule
